periph_receiver: RTL and testbench

//  Responder end of the cpu_send/cpu_ack/cpu_dados 4-phase handshake. Receives each nibble
//  the CPU presents and acknowledges it. Buffers received nibbles in a small FIFO for a

---
 rtl/periph_pkg.sv | 14 +
 rtl/periph_receiver_if.sv | 11 +
 rtl/periph_fifo.sv | 56 +++++
 rtl/periph_receiver.sv | 91 +++++++++
 tb/tb_periph_receiver.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/periph_pkg.sv
// Shared definitions for the CPU/peripheral nibble handshake link.
// Holds the receiver state encoding and the default link geometry.
package periph_pkg;

    localparam int PERIPH_DATA_W = 4;
    localparam int PERIPH_DEPTH  = 4;
    localparam int PERIPH_CNT_W  = 8;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } periph_state_e;

endpackage

// File: rtl/periph_receiver_if.sv
// 4-phase send/ack/dados handshake between the CPU (master) and the peripheral receiver (slave).
interface periph_receiver_if #(
    parameter int DATA_W = periph_pkg::PERIPH_DATA_W
);
    logic              periph_send;
    logic [DATA_W-1:0] periph_dados;
    logic              periph_ack;

    modport master (output periph_send, output periph_dados, input periph_ack);
    modport slave  (input periph_send, input periph_dados, output periph_ack);
endinterface

// File: rtl/periph_fifo.sv
// Circular DEPTH x DATA_W FIFO with combinational head read and occupancy count.
// The caller must not push while full; pops while empty are ignored.
module periph_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          rd_data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              pop_ok;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign pop_ok    = pop_i && !empty_o;
    assign count_o   = count_q;
    // Head reads as zero when empty so the output is defined straight out of reset.
    assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        unique case ({push_i, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end
endmodule

// File: rtl/periph_receiver.sv
// Responder end of the send/ack/dados 4-phase handshake; buffers each nibble in a FIFO.
// Define PERIPH_SYNC_EN to pass periph_send through a 2-flop synchronizer first.
module periph_receiver
    import periph_pkg::*;
#(
    parameter int DATA_W = PERIPH_DATA_W,
    parameter int DEPTH  = PERIPH_DEPTH,
    parameter int CNT_W  = PERIPH_CNT_W
) (
    input  logic                    periph_clock,
    input  logic                    periph_reset,
    periph_receiver_if.slave        hs,
    input  logic                    rd_en,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic [CNT_W-1:0]        rx_count
);
    periph_state_e     state_q;
    logic              ack_q;
    logic [CNT_W-1:0]  rx_count_q;
    logic              send_s;
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              push;

`ifdef PERIPH_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge periph_clock) begin
        if (periph_reset) sync_q <= '0;
        else              sync_q <= {sync_q[0], hs.periph_send};
    end

    assign send_s = sync_q[1];
`else
    assign send_s = hs.periph_send;
`endif

    // Full is judged on the pre-edge count, so a same-cycle pop never admits the push.
    assign accept = (state_q == IDLE) && send_s && !fifo_full;
    assign push   = accept && !periph_reset;

    always_ff @(posedge periph_clock) begin
        if (periph_reset) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            rx_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ack_q      <= 1'b1;
                        rx_count_q <= rx_count_q + 1'b1;
                        state_q    <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (!send_s) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    periph_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (periph_clock),
        .srst        (periph_reset),
        .push_i      (push),
        .push_data_i (hs.periph_dados),
        .pop_i       (rd_en),
        .rd_data_o   (rd_data),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full),
        .count_o     (fifo_count)
    );

    assign hs.periph_ack = ack_q;
    assign rd_valid      = !fifo_empty;
    assign rx_count      = rx_count_q;
endmodule

// File: tb/tb_periph_receiver.sv
// Directed self-checking bench for periph_receiver (built with CNT_W=4 to exercise counter wrap).
// Honours PERIPH_SYNC_EN for the expected accept/release latency.
module tb_periph_receiver;
    import periph_pkg::*;

`ifdef PERIPH_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rd_en = 1'b0;
    logic [3:0] rd_data;
    logic       rd_valid;
    logic [2:0] fifo_count;
    logic [3:0] rx_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_rx   = 0;

    periph_receiver_if #(.DATA_W(4)) hs_if ();

    periph_receiver #(
        .DATA_W (4),
        .DEPTH  (4),
        .CNT_W  (4)
    ) dut (
        .periph_clock (clk),
        .periph_reset (rst),
        .hs           (hs_if.slave),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .fifo_count   (fifo_count),
        .rx_count     (rx_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    // Full handshake; returns edges until ack rose and edges until it fell.
    task automatic handshake(input logic [3:0] d, output int up_edges, output int dn_edges);
        hs_if.periph_dados = d;
        hs_if.periph_send  = 1'b1;
        up_edges = 0;
        while (hs_if.periph_ack !== 1'b1 && up_edges < 20) begin
            tick();
            up_edges++;
        end
        chk("hs_ack_rise", int'(hs_if.periph_ack), 1);
        hs_if.periph_send = 1'b0;
        dn_edges = 0;
        while (hs_if.periph_ack !== 1'b0 && dn_edges < 20) begin
            tick();
            dn_edges++;
        end
        chk("hs_ack_fall", int'(hs_if.periph_ack), 0);
        exp_rx = (exp_rx + 1) % 16;
        $display("handshake data=%h up=%0d dn=%0d", d, up_edges, dn_edges);
    endtask

    task automatic pop_check(input logic [3:0] exp);
        chk("pop_valid", int'(rd_valid), 1);
        chk("pop_data", int'(rd_data), int'(exp));
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        hs_if.periph_send  = 1'b1;
        hs_if.periph_dados = 4'h5;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_ack", int'(hs_if.periph_ack), 0);
            chk("reset_valid", int'(rd_valid), 0);
            chk("reset_count", int'(fifo_count), 0);
            chk("reset_rx", int'(rx_count), 0);
        end
        chk("reset_rd_data", int'(rd_data), 0);
        hs_if.periph_send = 1'b0;
        rst = 1'b0;
        exp_rx = 0;
        tick();
    endtask

    task automatic test_single();
        int up, dn;
        handshake(4'hA, up, dn);
        chk("single_up_latency", up, LAT);
        chk("single_dn_latency", dn, LAT);
        chk("single_rd_data", int'(rd_data), 10);
        chk("single_count", int'(fifo_count), 1);
        chk("single_rx", int'(rx_count), 1);
        pop_check(4'hA);
        chk("single_empty", int'(rd_valid), 0);
    endtask

    task automatic test_backpressure();
        int up, dn;
        for (int i = 1; i <= 4; i++) handshake(4'(i), up, dn);
        chk("bp_full_count", int'(fifo_count), 4);
        hs_if.periph_dados = 4'h5;
        hs_if.periph_send  = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("bp_ack_held_low", int'(hs_if.periph_ack), 0);
        chk("bp_rx_no_push", int'(rx_count), exp_rx);
        pop_check(4'h1);
        chk("bp_ack_low_at_pop", int'(hs_if.periph_ack), 0);
        chk("bp_count_after_pop", int'(fifo_count), 3);
        tick();
        chk("bp_ack_after_pop", int'(hs_if.periph_ack), 1);
        chk("bp_count_refill", int'(fifo_count), 4);
        hs_if.periph_send = 1'b0;
        up = 0;
        while (hs_if.periph_ack !== 1'b0 && up < 20) begin
            tick();
            up++;
        end
        chk("bp_ack_fall", int'(hs_if.periph_ack), 0);
        exp_rx = (exp_rx + 1) % 16;
        chk("bp_rx", int'(rx_count), exp_rx);
        for (int i = 2; i <= 5; i++) pop_check(4'(i));
        chk("bp_drained", int'(fifo_count), 0);
    endtask

    task automatic test_send_held();
        int k;
        hs_if.periph_dados = 4'h7;
        hs_if.periph_send  = 1'b1;
        k = 0;
        while (hs_if.periph_ack !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        chk("held_ack_rise", int'(hs_if.periph_ack), 1);
        for (int i = 0; i < 10; i++) tick();
        chk("held_ack_still_high", int'(hs_if.periph_ack), 1);
        chk("held_one_push", int'(fifo_count), 1);
        hs_if.periph_send = 1'b0;
        k = 0;
        while (hs_if.periph_ack !== 1'b0 && k < 20) begin
            tick();
            k++;
        end
        chk("held_ack_fall", int'(hs_if.periph_ack), 0);
        exp_rx = (exp_rx + 1) % 16;
        chk("held_rx", int'(rx_count), exp_rx);
        chk("held_count_final", int'(fifo_count), 1);
        pop_check(4'h7);
    endtask

    task automatic test_push_pop();
        int up, dn, k;
        handshake(4'h8, up, dn);
        handshake(4'h9, up, dn);
        chk("pp_count_before", int'(fifo_count), 2);
        hs_if.periph_dados = 4'hA;
        hs_if.periph_send  = 1'b1;
        for (int i = 0; i < LAT - 1; i++) tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("pp_ack", int'(hs_if.periph_ack), 1);
        chk("pp_count_same", int'(fifo_count), 2);
        hs_if.periph_send = 1'b0;
        k = 0;
        while (hs_if.periph_ack !== 1'b0 && k < 20) begin
            tick();
            k++;
        end
        chk("pp_ack_fall", int'(hs_if.periph_ack), 0);
        exp_rx = (exp_rx + 1) % 16;
        pop_check(4'h9);
        pop_check(4'hA);
        chk("pp_rx", int'(rx_count), exp_rx);
    endtask

    task automatic test_wrap();
        int up, dn;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_rx = 0;
        chk("wrap_rx_reset", int'(rx_count), 0);
        for (int i = 0; i < 17; i++) begin
            handshake(4'(i), up, dn);
            chk("wrap_latency", up, LAT);
            pop_check(4'(i));
        end
        chk("wrap_rx", int'(rx_count), 1);
    endtask

    initial begin
        hs_if.periph_send  = 1'b0;
        hs_if.periph_dados = 4'h0;
        test_reset();
        test_single();
        test_backpressure();
        test_send_held();
        test_push_pop();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
